// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : uart_tx_arbiter
// Description: Shares a single UartTx between NREQ byte producers. The block
//              arbitrates round-robin, lets a requester hold the grant for a
//              bounded burst, issues the one-cycle Start pulse, and watches
//              for a UartTx that never leaves the complete state.
// Revision   : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 16,
    parameter int BUSY_TO   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_lock,
    output logic [NREQ-1:0]         req_ready,
    output logic [7:0]              tx_DataByte,
    output logic                    tx_Start,
    input  logic                    tx_fComplete,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    err_stall,
    input  logic                    err_clr
);

    localparam int IDW = $clog2(NREQ);

    // Highest legal requester index; the pointer wraps to zero after it.
    localparam logic [IDW-1:0] c_last_id    = IDW'(NREQ - 1);
    // A locked grant may be extended while fewer than BURST_MAX-1 extra
    // bytes have been sent, giving at most BURST_MAX frames per grant.
    localparam logic [7:0]     c_burst_last = 8'(BURST_MAX - 1);
    // The stall fires on the cycle the incremented count reaches BUSY_TO-1,
    // i.e. when the current count equals BUSY_TO-2.
    localparam logic [7:0]     c_to_stall   = 8'(BUSY_TO - 2);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  w_rr_ptr_nxt;
    logic [7:0]      r_burst_cnt;
    logic [7:0]      w_burst_cnt_nxt;
    logic [7:0]      r_to_cnt;
    logic [7:0]      w_to_cnt_nxt;
    logic [7:0]      r_tx_data;
    logic [7:0]      w_tx_data_nxt;
    logic [IDW-1:0]  r_grant_id;
    logic [IDW-1:0]  w_grant_id_nxt;
    logic            r_tx_start;
    logic            w_tx_start_nxt;
    logic [NREQ-1:0] r_req_ready;
    logic [NREQ-1:0] w_req_ready_nxt;
    logic            r_busy;
    logic            r_err_stall;
    logic            w_stall_set;

    logic [7:0]      w_req_bytes [NREQ];
    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_grant_inc;

    // Split the flat data bus into one byte per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_req_bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Rotation successor of the current grant, wrapping at NREQ-1.
    assign w_grant_inc = (r_grant_id == c_last_id) ? '0 : r_grant_id + IDW'(1);

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (!w_found && req_valid[v_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = v_idx[IDW-1:0];
            end
        end
    end

    // Next-state and next-output logic of the issue sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_burst_cnt_nxt = r_burst_cnt;
        w_to_cnt_nxt    = r_to_cnt;
        w_tx_data_nxt   = r_tx_data;
        w_grant_id_nxt  = r_grant_id;
        w_tx_start_nxt  = 1'b0;
        w_req_ready_nxt = '0;
        w_stall_set     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Never start while UartTx is still busy; this also protects
                // a frame that was in flight across a reset.
                if (tx_fComplete && w_found) begin
                    w_tx_data_nxt          = w_req_bytes[w_win];
                    w_grant_id_nxt         = w_win;
                    w_burst_cnt_nxt        = '0;
                    w_tx_start_nxt         = 1'b1;
                    w_req_ready_nxt[w_win] = 1'b1;
                    w_state_nxt            = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                w_to_cnt_nxt = '0;
                w_state_nxt  = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (!tx_fComplete) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_to_cnt == c_to_stall) begin
                    // UartTx never acknowledged the Start; drop the byte and
                    // move on so one dead transmitter cannot hang producers.
                    w_stall_set  = 1'b1;
                    w_rr_ptr_nxt = w_grant_inc;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 8'd1;
                end
            end

            ST_WAIT_DONE: begin
                if (tx_fComplete) begin
                    if (req_lock[r_grant_id] && req_valid[r_grant_id] &&
                        (r_burst_cnt < c_burst_last)) begin
                        w_burst_cnt_nxt             = r_burst_cnt + 8'd1;
                        w_tx_data_nxt               = w_req_bytes[r_grant_id];
                        w_tx_start_nxt              = 1'b1;
                        w_req_ready_nxt[r_grant_id] = 1'b1;
                        w_state_nxt                 = ST_ISSUE;
                    end else begin
                        w_rr_ptr_nxt = w_grant_inc;
                        w_state_nxt  = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_to_cnt    <= '0;
            r_tx_data   <= '0;
            r_grant_id  <= '0;
            r_tx_start  <= 1'b0;
            r_req_ready <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Sticky stall flag; a new stall wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_stall <= 1'b0;
        end else if (w_stall_set) begin
            r_err_stall <= 1'b1;
        end else if (err_clr) begin
            r_err_stall <= 1'b0;
        end
    end

    assign req_ready   = r_req_ready;
    assign tx_DataByte = r_tx_data;
    assign tx_Start    = r_tx_start;
    assign grant_id    = r_grant_id;
    assign busy        = r_busy;
    assign err_stall   = r_err_stall;

endmodule
`default_nettype wire
